// File: rtl/spi_arbiter_pkg.sv
// Shared types and sizing helpers for the SPI engine arbiter.
// The FSM state encodings are fixed 3-bit values so they can be probed on a bus analyser.
package spi_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_RESP      = 3'd5,
    ST_HOLD      = 3'd6,
    ST_RELEASE   = 3'd7
  } arb_state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Requester, chip-select and byte-engine signals of the SPI arbiter.
// The slave modport is the arbiter side; the master modport is the requesters plus the engine.
interface spi_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_last;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ack;
  logic [N_REQ-1:0]   rsp_valid;
  logic [7:0]         rsp_data;
  logic [N_REQ-1:0]   cs_n;
  logic               busy;
  logic [7:0]         eng_data;
  logic               eng_send_rq;
  logic [7:0]         eng_rx_data;
  logic               eng_tx_ready;

  modport slave (
    input  req_valid, req_last, req_data, eng_rx_data, eng_tx_ready,
    output req_ack, rsp_valid, rsp_data, cs_n, busy, eng_data, eng_send_rq
  );

  modport master (
    output req_valid, req_last, req_data, eng_rx_data, eng_tx_ready,
    input  req_ack, rsp_valid, rsp_data, cs_n, busy, eng_data, eng_send_rq
  );
endinterface

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer wins.
module spi_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);
  int pos_s;

  // scan requesters starting from the pointer, wrapping at N_REQ
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos_s   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      pos_s = (int'(ptr_i) + i) % N_REQ;
      if (!any_o && req_i[pos_s]) begin
        grant_o[pos_s] = 1'b1;
        idx_o          = IDX_W'(pos_s);
        any_o          = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end
endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin owner of a shared SPI byte engine with CS setup/hold sequencing.
// Optional HOLD idle timeout with sticky per-requester flags: define SPI_ARB_TIMEOUT_EN.
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int CS_SETUP     = 2,
  parameter int CS_HOLD      = 2,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic             cpu_clk,
  input  logic             rst,
  spi_arbiter_if.slave     bus
`ifdef SPI_ARB_TIMEOUT_EN
  ,
  output logic [N_REQ-1:0] timeout_flag
`endif
);
  localparam int IDX_W = idx_width(N_REQ);
  localparam int CNT_W = cnt_width((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);

  if (N_REQ < 1 || N_REQ > 8 || CS_SETUP < 1 || CS_HOLD < 1 || HOLD_TIMEOUT < 1) begin : g_param_chk
    $error("spi_arbiter: parameter out of range");
  end

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d, ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [N_REQ-1:0] cs_n_q, cs_n_d, req_ack_q, req_ack_d, rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d, send_q, send_d;
  logic [7:0]       eng_data_q, eng_data_d, rsp_data_q, rsp_data_d;
  logic [N_REQ-1:0] owner_oh_s, gnt_oh_s;
  logic [IDX_W-1:0] gnt_idx_s;
  logic             gnt_any_s;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_W = cnt_width(HOLD_TIMEOUT);
  logic [TO_W-1:0]  idle_q, idle_d;
  logic [N_REQ-1:0] tflag_q, tflag_d;
  assign timeout_flag = tflag_q;
`endif

  spi_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (gnt_oh_s),
    .idx_o   (gnt_idx_s),
    .any_o   (gnt_any_s)
  );

  // one-hot decode of the current owner
  always_comb begin
    owner_oh_s = '0;
    owner_oh_s[owner_q] = 1'b1;
  end

  // transaction sequencer: next state and registered-output next values
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    cs_n_d      = cs_n_q;
    busy_d      = busy_q;
    eng_data_d  = eng_data_q;
    rsp_data_d  = rsp_data_q;
    send_d      = 1'b0;
    req_ack_d   = '0;
    rsp_valid_d = '0;
`ifdef SPI_ARB_TIMEOUT_EN
    idle_d      = idle_q;
    tflag_d     = tflag_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt_any_s) begin
          owner_d = gnt_idx_s;
          cs_n_d  = ~gnt_oh_s;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(CS_SETUP);
          state_d = ST_SETUP;
`ifdef SPI_ARB_TIMEOUT_EN
          tflag_d = tflag_q & ~gnt_oh_s;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_SEND;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SEND: begin
        if (bus.req_valid[owner_q] && bus.eng_tx_ready) begin
          eng_data_d = bus.req_data[{owner_q, 3'b000} +: 8];
          send_d     = 1'b1;
          req_ack_d  = owner_oh_s;
          last_d     = bus.req_last[owner_q];
          state_d    = ST_WAIT_BUSY;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT_BUSY: begin
        // the send pulse is visible for one cycle before the engine drops ready
        if (!bus.eng_tx_ready) begin
          state_d = ST_WAIT_DONE;
        end else begin
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.eng_tx_ready) begin
          rsp_data_d  = bus.eng_rx_data;
          rsp_valid_d = owner_oh_s;
          state_d     = ST_RESP;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_RESP: begin
`ifdef SPI_ARB_TIMEOUT_EN
        idle_d = '0;
`endif
        if (last_q) begin
          cnt_d   = CNT_W'(CS_HOLD);
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.req_valid[owner_q]) begin
          state_d = ST_SEND;
`ifdef SPI_ARB_TIMEOUT_EN
        end else if (idle_q == TO_W'(HOLD_TIMEOUT - 1)) begin
          cnt_d   = CNT_W'(CS_HOLD);
          tflag_d = tflag_q | owner_oh_s;
          state_d = ST_RELEASE;
        end else begin
          idle_d = idle_q + TO_W'(1);
`else
        end else begin
          state_d = ST_HOLD;
`endif
        end
      end
      ST_RELEASE: begin
        if (cnt_q == CNT_W'(1)) begin
          cs_n_d  = '1;
          busy_d  = 1'b0;
          ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cs_n_d  = '1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and output registers with synchronous reset
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      cs_n_q      <= '1;
      busy_q      <= 1'b0;
      send_q      <= 1'b0;
      req_ack_q   <= '0;
      rsp_valid_q <= '0;
      eng_data_q  <= 8'h00;
      rsp_data_q  <= 8'h00;
`ifdef SPI_ARB_TIMEOUT_EN
      idle_q      <= '0;
      tflag_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
      send_q      <= send_d;
      req_ack_q   <= req_ack_d;
      rsp_valid_q <= rsp_valid_d;
      eng_data_q  <= eng_data_d;
      rsp_data_q  <= rsp_data_d;
`ifdef SPI_ARB_TIMEOUT_EN
      idle_q      <= idle_d;
      tflag_q     <= tflag_d;
`endif
    end
  end

  assign bus.cs_n        = cs_n_q;
  assign bus.busy        = busy_q;
  assign bus.eng_send_rq = send_q;
  assign bus.eng_data    = eng_data_q;
  assign bus.req_ack     = req_ack_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a behavioural byte engine (ready drops after a send pulse,
// returns the programmed reply ENG_DLY cycles later) and a cycle-stamping monitor.
module tb_spi_arbiter;
  localparam int N       = 2;
  localparam int ENG_DLY = 3;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int HOLD_IDLE = 6;
`else
  localparam int HOLD_IDLE = 10;
`endif

  logic cpu_clk = 1'b0;
  logic rst;
  always #5 cpu_clk = ~cpu_clk;

  spi_arbiter_if #(.N_REQ(N)) bus ();
`ifdef SPI_ARB_TIMEOUT_EN
  logic [N-1:0] timeout_flag;
`endif

  spi_arbiter #(.N_REQ(N), .CS_SETUP(2), .CS_HOLD(2), .HOLD_TIMEOUT(8)) dut (
    .cpu_clk (cpu_clk),
    .rst     (rst),
    .bus     (bus)
`ifdef SPI_ARB_TIMEOUT_EN
    ,
    .timeout_flag (timeout_flag)
`endif
  );

  int n_checks, n_fail;
  int cyc = 0;
  int dly = 0;
  logic [7:0] reply;
  logic [7:0] pulse_data = 8'h00;
  int pulse_cyc = 0, rsp_cyc = 0, overlap_err = 0, hold_err = 0;
  int ack_cnt[N], rsp_cnt[N], cs_fall_cyc[N], cs_rise_cyc[N], cs_rise_cnt[N], sent[N];
  logic [N-1:0] cs_prev = '1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // engine model plus event monitor, all at the falling edge
  always @(negedge cpu_clk) begin
    cyc = cyc + 1;
    if (rst === 1'b1) begin
      bus.eng_tx_ready = 1'b1;
      bus.eng_rx_data  = 8'h00;
      dly = 0;
    end else if (bus.eng_send_rq === 1'b1) begin
      bus.eng_tx_ready = 1'b0;
      dly        = ENG_DLY;
      pulse_cyc  = cyc;
      pulse_data = bus.eng_data;
    end else if (bus.eng_tx_ready === 1'b0) begin
      if (bus.eng_data !== pulse_data) hold_err++;
      if (dly == 0) begin
        bus.eng_tx_ready = 1'b1;
        bus.eng_rx_data  = reply;
      end else begin
        dly--;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (cs_prev[i] === 1'b1 && bus.cs_n[i] === 1'b0) cs_fall_cyc[i] = cyc;
      if (cs_prev[i] === 1'b0 && bus.cs_n[i] === 1'b1) begin
        cs_rise_cyc[i] = cyc;
        cs_rise_cnt[i]++;
      end
      if (bus.req_ack[i] === 1'b1) ack_cnt[i]++;
      if (bus.rsp_valid[i] === 1'b1) begin
        rsp_cnt[i]++;
        rsp_cyc = cyc;
      end
    end
    if ($countones(~bus.cs_n) > 1) overlap_err++;
    cs_prev = bus.cs_n;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge cpu_clk);
      #1;
    end
  endtask

  task automatic drive(input int r, input logic [7:0] d, input logic l);
    bus.req_valid[r]       = 1'b1;
    bus.req_last[r]        = l;
    bus.req_data[8*r +: 8] = d;
    sent[r]++;
  endtask

  task automatic wait_ack(input int r, input string tag);
    int n = 0;
    while (bus.req_ack[r] !== 1'b1 && n < 60) begin
      step(1);
      n++;
    end
    check_eq({tag, "_ack"}, 32'(bus.req_ack[r]), 32'd1);
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic wait_first(input logic [N-1:0] exp, input string tag);
    int n = 0;
    while (bus.req_ack === '0 && n < 60) begin
      step(1);
      n++;
    end
    check_eq(tag, 32'(bus.req_ack), 32'(exp));
    bus.req_valid = bus.req_valid & ~exp;
  endtask

  task automatic wait_rsp(input int r, input logic [7:0] exp, input string tag);
    int n = 0;
    while (bus.rsp_valid[r] !== 1'b1 && n < 60) begin
      step(1);
      n++;
    end
    check_eq({tag, "_rsp_valid"}, 32'(bus.rsp_valid[r]), 32'd1);
    check_eq({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(exp));
  endtask

  initial begin
    int n;
    int ack1_before, rise_before, ack0_before, rsp_before;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < N; i++) begin
      ack_cnt[i] = 0; rsp_cnt[i] = 0; cs_fall_cyc[i] = 0;
      cs_rise_cyc[i] = 0; cs_rise_cnt[i] = 0; sent[i] = 0;
    end
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    reply = 8'h00;
    rst   = 1'b1;
    step(3);
    check_eq("rst_cs_n", 32'(bus.cs_n), 32'h3);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_send_rq", 32'(bus.eng_send_rq), 32'd0);
    check_eq("rst_eng_data", 32'(bus.eng_data), 32'h00);
    check_eq("rst_rsp_data", 32'(bus.rsp_data), 32'h00);
    check_eq("rst_ack_rsp", 32'({bus.req_ack, bus.rsp_valid}), 32'h0);
    rst = 1'b0;
    step(2);

    // single last byte from req0
    reply = 8'h3C;
    drive(0, 8'hA5, 1'b1);
    wait_ack(0, "t1");
    check_eq("t1_eng_data", 32'(pulse_data), 32'hA5);
    check_eq("t1_setup_lat", 32'(pulse_cyc - cs_fall_cyc[0]), 32'd3);
    wait_rsp(0, 8'h3C, "t1");
    step(5);
    check_eq("t1_hold_lat", 32'(cs_rise_cyc[0] - rsp_cyc), 32'd3);
    check_eq("t1_acks", 32'(ack_cnt[0]), 32'd1);
    check_eq("t1_busy_end", 32'(bus.busy), 32'd0);

    // pointer now past req0: simultaneous requests go to req1 first
    reply = 8'h99;
    drive(0, 8'hC0, 1'b1);
    drive(1, 8'hC1, 1'b1);
    wait_first(2'b10, "rr_req1_first");
    wait_rsp(1, 8'h99, "rr1");
    wait_ack(0, "rr_req0_second");
    wait_rsp(0, 8'h99, "rr0");
    step(4);

    // 3-byte burst from req0 while req1 is requesting
    drive(0, 8'h01, 1'b0);
    n = 0;
    while (bus.cs_n[0] !== 1'b0 && n < 20) begin
      step(1);
      n++;
    end
    rise_before = cs_rise_cnt[0];
    ack1_before = ack_cnt[1];
    drive(1, 8'hE1, 1'b1);
    reply = 8'h81; wait_ack(0, "t2_b1"); wait_rsp(0, 8'h81, "t2_b1");
    drive(0, 8'h02, 1'b0);
    reply = 8'h82; wait_ack(0, "t2_b2"); wait_rsp(0, 8'h82, "t2_b2");
    drive(0, 8'h03, 1'b1);
    reply = 8'h83; wait_ack(0, "t2_b3"); wait_rsp(0, 8'h83, "t2_b3");
    check_eq("t2_last_eng_data", 32'(pulse_data), 32'h03);
    step(3);
    check_eq("t2_cs0_released", 32'(bus.cs_n[0]), 32'd1);
    check_eq("t2_cs0_single_rise", 32'(cs_rise_cnt[0] - rise_before), 32'd1);
    check_eq("t2_no_preempt", 32'(ack_cnt[1] - ack1_before), 32'd0);
    reply = 8'hE7;
    wait_ack(1, "t2_req1");
    check_eq("t2_cs_gap", 32'(cs_fall_cyc[1] - cs_rise_cyc[0]), 32'd1);
    wait_rsp(1, 8'hE7, "t2_req1");
    step(4);

    // reset while waiting for the engine to finish
    reply = 8'h44;
    drive(0, 8'h4D, 1'b1);
    wait_ack(0, "t4");
    step(1);
    rsp_before = rsp_cnt[0];
    rst = 1'b1;
    step(1);
    check_eq("t4_cs_n", 32'(bus.cs_n), 32'h3);
    check_eq("t4_busy", 32'(bus.busy), 32'd0);
    check_eq("t4_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    step(1);
    rst = 1'b0;
    step(8);
    check_eq("t4_no_rsp", 32'(rsp_cnt[0] - rsp_before), 32'd0);
    check_eq("t4_idle_cs", 32'(bus.cs_n), 32'h3);

    // simultaneous requests straight out of reset: req0 wins
    reply = 8'h5A;
    drive(0, 8'hD0, 1'b1);
    drive(1, 8'hD1, 1'b1);
    wait_first(2'b01, "rst_req0_first");
    wait_rsp(0, 8'h5A, "t5_0");
    wait_ack(1, "t5_req1_second");
    wait_rsp(1, 8'h5A, "t5_1");
    step(4);

    // owner idles in HOLD, another requester waits, then owner finishes
    reply = 8'h21;
    drive(0, 8'h10, 1'b0);
    wait_ack(0, "t6_b1");
    wait_rsp(0, 8'h21, "t6_b1");
    rise_before = cs_rise_cnt[0];
    ack0_before = ack_cnt[0];
    ack1_before = ack_cnt[1];
    drive(1, 8'h6E, 1'b1);
    step(HOLD_IDLE);
    check_eq("t6_cs_held", 32'(bus.cs_n), 32'h2);
    check_eq("t6_busy_held", 32'(bus.busy), 32'd1);
    reply = 8'hAA;
    drive(0, 8'h55, 1'b1);
    wait_ack(0, "t6_b2");
    check_eq("t6_eng_data", 32'(pulse_data), 32'h55);
    wait_rsp(0, 8'hAA, "t6_b2");
    check_eq("t6_one_ack", 32'(ack_cnt[0] - ack0_before), 32'd1);
    check_eq("t6_no_release", 32'(cs_rise_cnt[0] - rise_before), 32'd0);
    check_eq("t6_req1_waits", 32'(ack_cnt[1] - ack1_before), 32'd0);
    reply = 8'h6F;
    wait_ack(1, "t6_req1");
    wait_rsp(1, 8'h6F, "t6_req1");
    step(4);

`ifdef SPI_ARB_TIMEOUT_EN
    // silent owner is forced off the bus and flagged
    reply = 8'h07;
    drive(0, 8'h70, 1'b0);
    wait_ack(0, "t7_b1");
    wait_rsp(0, 8'h07, "t7_b1");
    step(20);
    check_eq("t7_cs_released", 32'(bus.cs_n), 32'h3);
    check_eq("t7_flag_set", 32'(timeout_flag), 32'h1);
    drive(0, 8'h71, 1'b1);
    wait_ack(0, "t7_b2");
    check_eq("t7_flag_cleared", 32'(timeout_flag), 32'h0);
    wait_rsp(0, 8'h07, "t7_b2");
    step(4);
`endif

    check_eq("total_acks_req0", 32'(ack_cnt[0]), 32'(sent[0]));
    check_eq("total_acks_req1", 32'(ack_cnt[1]), 32'(sent[1]));
    check_eq("cs_never_overlap", 32'(overlap_err), 32'd0);
    check_eq("eng_data_stable", 32'(hold_err), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
